// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter for the register file's single write port. Requesters A (ALU) and
// M (memory load) compete for the port. Each grant produces a one-cycle ACK and a registered
// write (write_o/inaddress_o/in_o). A pending-write scoreboard flags read hazards.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   hold_i                     blocks new grants; the write already in the output stage finishes
//   req_a_i/addr_a_i/data_a_i  requester A request, destination register and data
//   ack_a_o                    one-cycle grant pulse to A
//   req_m_i/addr_m_i/data_m_i  requester M request, destination register and data
//   ack_m_o                    one-cycle grant pulse to M
//   write_o/inaddress_o/in_o   register file write enable, address and data
//   chk_en{1,2}_i, chk_addr{1,2}_i  read-port hazard checks
//   stall_o                    combinational hazard flag
//   pending_o                  per-register outstanding-write mask
module reg_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         hold_i,
    input  logic                         req_a_i,
    input  logic [ADDR_WIDTH-1:0]        addr_a_i,
    input  logic [DATA_WIDTH-1:0]        data_a_i,
    output logic                         ack_a_o,
    input  logic                         req_m_i,
    input  logic [ADDR_WIDTH-1:0]        addr_m_i,
    input  logic [DATA_WIDTH-1:0]        data_m_i,
    output logic                         ack_m_o,
    output logic                         write_o,
    output logic [ADDR_WIDTH-1:0]        inaddress_o,
    output logic [DATA_WIDTH-1:0]        in_o,
    input  logic                         chk_en1_i,
    input  logic [ADDR_WIDTH-1:0]        chk_addr1_i,
    input  logic                         chk_en2_i,
    input  logic [ADDR_WIDTH-1:0]        chk_addr2_i,
    output logic                         stall_o,
    output logic [(2**ADDR_WIDTH)-1:0]   pending_o
);

    localparam int unsigned NumRegs = 2**ADDR_WIDTH;

    // Which requester received the most recent grant.
    typedef enum logic {LastA = 1'b0, LastM = 1'b1} last_e;

    last_e                 last_q;
    logic                  ack_a_q;
    logic                  ack_m_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] inaddress_q;
    logic [DATA_WIDTH-1:0] in_q;

    logic elig_a;
    logic elig_m;
    logic grant_a;
    logic grant_m;

    // A request whose ACK is still high is the one just served; excluding it stops a double grant.
    assign elig_a = req_a_i & ~ack_a_q & ~hold_i;
    assign elig_m = req_m_i & ~ack_m_q & ~hold_i;

    // On conflict the requester not granted last wins.
    assign grant_a = elig_a & (~elig_m | (last_q == LastM));
    assign grant_m = elig_m & (~elig_a | (last_q == LastA));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= LastM;
            ack_a_q     <= 1'b0;
            ack_m_q     <= 1'b0;
            write_q     <= 1'b0;
            inaddress_q <= '0;
            in_q        <= '0;
        end else begin
            ack_a_q <= grant_a;
            ack_m_q <= grant_m;
            write_q <= grant_a | grant_m;
            if (grant_a) begin
                last_q      <= LastA;
                inaddress_q <= addr_a_i;
                in_q        <= data_a_i;
            end else if (grant_m) begin
                last_q      <= LastM;
                inaddress_q <= addr_m_i;
                in_q        <= data_m_i;
            end
        end
    end

    assign ack_a_o     = ack_a_q;
    assign ack_m_o     = ack_m_q;
    assign write_o     = write_q;
    assign inaddress_o = inaddress_q;
    assign in_o        = in_q;

    // A register is pending while a request for it is unserved or its write is in the output stage.
    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            pending_o[i] = (req_a_i & ~ack_a_q & (addr_a_i == ADDR_WIDTH'(i))) |
                           (req_m_i & ~ack_m_q & (addr_m_i == ADDR_WIDTH'(i))) |
                           (write_q & (inaddress_q == ADDR_WIDTH'(i)));
        end
    end

    assign stall_o = (chk_en1_i & pending_o[chk_addr1_i]) | (chk_en2_i & pending_o[chk_addr2_i]);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       hold;
    logic       req_a, req_m;
    logic [2:0] addr_a, addr_m;
    logic [7:0] data_a, data_m;
    logic       ack_a_o, ack_m_o, write_o;
    logic [2:0] inaddress_o;
    logic [7:0] in_o;
    logic       chk_en1, chk_en2;
    logic [2:0] chk_addr1, chk_addr2;
    logic       stall_o;
    logic [7:0] pending_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: transaction-level view of what the port should show after each edge.
    logic       m_ack_a, m_ack_m, m_write;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    bit         m_last_was_m;
    logic [7:0] mdl_rf [8];
    logic [7:0] dut_rf [8];

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .hold_i      (hold),
        .req_a_i     (req_a),
        .addr_a_i    (addr_a),
        .data_a_i    (data_a),
        .ack_a_o     (ack_a_o),
        .req_m_i     (req_m),
        .addr_m_i    (addr_m),
        .data_m_i    (data_m),
        .ack_m_o     (ack_m_o),
        .write_o     (write_o),
        .inaddress_o (inaddress_o),
        .in_o        (in_o),
        .chk_en1_i   (chk_en1),
        .chk_addr1_i (chk_addr1),
        .chk_en2_i   (chk_en2),
        .chk_addr2_i (chk_addr2),
        .stall_o     (stall_o),
        .pending_o   (pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pending();
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (req_a && !m_ack_a && addr_a == 3'(i)) p[i] = 1'b1;
            if (req_m && !m_ack_m && addr_m == 3'(i)) p[i] = 1'b1;
            if (m_write && m_addr == 3'(i))           p[i] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic exp_stall();
        logic [7:0] p;
        p = exp_pending();
        return (chk_en1 && p[chk_addr1]) || (chk_en2 && p[chk_addr2]);
    endfunction

    task automatic model_reset();
        m_ack_a      = 1'b0;
        m_ack_m      = 1'b0;
        m_write      = 1'b0;
        m_addr       = '0;
        m_data       = '0;
        m_last_was_m = 1'b1;
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".pending"}, 32'(pending_o), 32'(exp_pending()));
        chk({tag, ".stall"}, 32'(stall_o), 32'(exp_stall()));
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ack_a"}, 32'(ack_a_o), 32'(m_ack_a));
        chk({tag, ".ack_m"}, 32'(ack_m_o), 32'(m_ack_m));
        chk({tag, ".write"}, 32'(write_o), 32'(m_write));
        chk({tag, ".inaddress"}, 32'(inaddress_o), 32'(m_addr));
        chk({tag, ".in"}, 32'(in_o), 32'(m_data));
        check_comb(tag);
    endtask

    // One clock edge: decide who should win from the rules, then compare #1 after the edge.
    task automatic step(input string tag);
        bit a_ok, m_ok, win_a, win_m;
        // The write currently on the port lands in the register file at this edge.
        if (m_write) mdl_rf[m_addr] = m_data;
        if (write_o) dut_rf[inaddress_o] = in_o;
        a_ok  = req_a && !m_ack_a && !hold;
        m_ok  = req_m && !m_ack_m && !hold;
        win_a = 1'b0;
        win_m = 1'b0;
        if (a_ok && m_ok) begin
            if (m_last_was_m) win_a = 1'b1;
            else              win_m = 1'b1;
        end else begin
            win_a = a_ok;
            win_m = m_ok;
        end
        @(posedge clk);
        #1;
        m_ack_a = win_a;
        m_ack_m = win_m;
        m_write = win_a || win_m;
        if (win_a) begin
            m_addr = addr_a;
            m_data = data_a;
            m_last_was_m = 1'b0;
        end else if (win_m) begin
            m_addr = addr_m;
            m_data = data_m;
            m_last_was_m = 1'b1;
        end
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mdl_rf[i] = '0;
            dut_rf[i] = '0;
        end
        rst_ni = 1'b0;
        hold = 1'b0;
        req_a = 1'b0; addr_a = '0; data_a = '0;
        req_m = 1'b0; addr_m = '0; data_m = '0;
        chk_en1 = 1'b0; chk_addr1 = '0;
        chk_en2 = 1'b0; chk_addr2 = '0;
        model_reset();

        // Reset with A requesting, then first grant goes to A.
        req_a = 1'b1; addr_a = 3'd3; data_a = 8'h5A;
        @(posedge clk);
        #1;
        check_all("reset_req");
        @(posedge clk);
        #1;
        check_all("reset_req2");
        rst_ni = 1'b1;
        step("single");
        chk("single.ack_a_const", 32'(ack_a_o), 32'd1);
        chk("single.inaddr_const", 32'(inaddress_o), 32'd3);
        chk("single.in_const", 32'(in_o), 32'h5A);
        req_a = 1'b0;
        step("single_idle");
        chk("single_idle.pending_const", 32'(pending_o), 32'h00);

        // Continuous conflict from reset: A, M, A, M with WRITE high each cycle.
        do_reset();
        req_a = 1'b1; addr_a = 3'd1; data_a = 8'h11;
        req_m = 1'b1; addr_m = 3'd2; data_m = 8'h22;
        for (int k = 0; k < 4; k++) begin
            step("rr");
            chk("rr.ack_a_order", 32'(ack_a_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr.write_const", 32'(write_o), 32'd1);
        end
        req_a = 1'b0;
        req_m = 1'b0;
        step("rr_idle");

        // Same destination register: A first, M second, M's value survives.
        do_reset();
        req_a = 1'b1; addr_a = 3'd4; data_a = 8'hAA;
        req_m = 1'b1; addr_m = 3'd4; data_m = 8'hBB;
        #1;
        check_comb("same0");
        step("same1");
        chk("same1.in_const", 32'(in_o), 32'hAA);
        req_a = 1'b0;
        step("same2");
        chk("same2.in_const", 32'(in_o), 32'hBB);
        chk("same2.pending4", 32'(pending_o[4]), 32'd1);
        req_m = 1'b0;
        step("same3");
        chk("same3.pending4", 32'(pending_o[4]), 32'd0);
        chk("same3.r4", 32'(dut_rf[4]), 32'hBB);

        // Read hazard on R6.
        req_m = 1'b1; addr_m = 3'd6; data_m = 8'h66;
        chk_en1 = 1'b1; chk_addr1 = 3'd6;
        #1;
        check_comb("haz_pre");
        chk("haz_pre.stall_const", 32'(stall_o), 32'd1);
        step("haz_grant");
        chk("haz_grant.stall_const", 32'(stall_o), 32'd1);
        req_m = 1'b0;
        #1;
        check_comb("haz_write");
        step("haz_done");
        chk("haz_done.stall_const", 32'(stall_o), 32'd0);
        req_m = 1'b1;
        chk_addr1 = 3'd5;
        #1;
        chk("haz_other.stall_const", 32'(stall_o), 32'd0);
        chk_en2 = 1'b1; chk_addr2 = 3'd6;
        #1;
        chk("haz_port2.stall_const", 32'(stall_o), 32'd1);
        req_m = 1'b0; chk_en1 = 1'b0; chk_en2 = 1'b0;
        #1;
        check_comb("haz_clear");

        // HOLD blocks grants but keeps the request pending.
        hold = 1'b1;
        req_a = 1'b1; addr_a = 3'd7; data_a = 8'h77;
        repeat (3) begin
            step("hold");
            chk("hold.write_const", 32'(write_o), 32'd0);
            chk("hold.pending7", 32'(pending_o[7]), 32'd1);
        end
        hold = 1'b0;
        step("hold_rel");
        chk("hold_rel.ack_a_const", 32'(ack_a_o), 32'd1);

        // Reset during the write cycle drops WRITE immediately; the write never lands.
        rst_ni = 1'b0;
        #1;
        chk("rst_mid.write_const", 32'(write_o), 32'd0);
        model_reset();
        check_all("rst_mid");
        req_a = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        chk("rst_mid.r7", 32'(dut_rf[7]), 32'h00);

        // Random traffic following the requester handshake rules.
        for (int n = 0; n < 400; n++) begin
            if (!req_a || m_ack_a) begin
                req_a  = ($urandom_range(0, 3) != 0);
                addr_a = 3'($urandom);
                data_a = 8'($urandom);
            end
            if (!req_m || m_ack_m) begin
                req_m  = ($urandom_range(0, 3) != 0);
                addr_m = 3'($urandom);
                data_m = 8'($urandom);
            end
            hold      = ($urandom_range(0, 7) == 0);
            chk_en1   = 1'($urandom);
            chk_addr1 = 3'($urandom);
            chk_en2   = 1'($urandom);
            chk_addr2 = 3'($urandom);
            step("rand");
        end
        req_a = 1'b0;
        req_m = 1'b0;
        hold  = 1'b0;
        step("drain1");
        step("drain2");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rf[%0d]", i), 32'(dut_rf[i]), 32'(mdl_rf[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
